// File: rtl/fsab_bram_responder.sv
// fsab_bram_responder: FSAB target backed by a 2^MEM_WORDS_LOG2 x FSAB_DATA_W RAM.
// Request beats land in a CREDITS-deep FIFO. A small FSM drains the FIFO,
// performs writes under byte mask, and streams read bursts back on fsabi.
//
// Handshake: fsabo uses credits, with no ready signal. Each fsabo_valid cycle
// is one beat and takes one FIFO entry. Each entry dequeued returns exactly
// one one-cycle fsabo_credit pulse, registered, in the cycle after the
// dequeue. fsabi_valid has no back-pressure: each cycle it is high carries
// one read beat.
module fsab_bram_responder #(
    parameter int FSAB_DATA_W    = 64,
    parameter int FSAB_MASK_W    = 8,
    parameter int FSAB_ADDR_W    = 31,
    parameter int FSAB_LEN_W     = 3,
    parameter int FSAB_DID_W     = 4,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int CREDITS        = 8
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   fsabo_valid,
    input  logic                   fsabo_mode,
    input  logic [FSAB_DID_W-1:0]  fsabo_did,
    input  logic [FSAB_DID_W-1:0]  fsabo_subdid,
    input  logic [FSAB_ADDR_W-1:0] fsabo_addr,
    input  logic [FSAB_LEN_W-1:0]  fsabo_len,
    input  logic [FSAB_DATA_W-1:0] fsabo_data,
    input  logic [FSAB_MASK_W-1:0] fsabo_mask,
    output logic                   fsabo_credit,
    output logic                   fsabi_valid,
    output logic [FSAB_DID_W-1:0]  fsabi_did,
    output logic [FSAB_DID_W-1:0]  fsabi_subdid,
    output logic [FSAB_DATA_W-1:0] fsabi_data,
    output logic                   ovf_err,
    output logic [1:0]             dbg_state
);
    localparam int PTR_W = $clog2(CREDITS);
    localparam int CNT_W = FSAB_LEN_W + 1;
    localparam int AW    = MEM_WORDS_LOG2;
    localparam logic [PTR_W:0]   DEPTH     = (PTR_W + 1)'(CREDITS);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(CREDITS - 1);
    localparam logic [CNT_W-1:0] MAX_BEATS = CNT_W'(1 << FSAB_LEN_W);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;

    state_t                 r_state, w_next_state;
    logic [AW-1:0]          r_addr, w_next_addr;
    logic [CNT_W-1:0]       r_rem, w_next_rem;
    logic [FSAB_DID_W-1:0]  r_did, w_next_did, r_subdid, w_next_subdid;

    // Request FIFO storage (no reset: contents are qualified by r_count)
    logic                   r_q_mode   [CREDITS];
    logic [FSAB_DID_W-1:0]  r_q_did    [CREDITS];
    logic [FSAB_DID_W-1:0]  r_q_subdid [CREDITS];
    logic [AW-1:0]          r_q_addr   [CREDITS];
    logic [FSAB_LEN_W-1:0]  r_q_len    [CREDITS];
    logic [FSAB_DATA_W-1:0] r_q_data   [CREDITS];
    logic [FSAB_MASK_W-1:0] r_q_mask   [CREDITS];
    logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]         r_count;

    logic [FSAB_DATA_W-1:0] r_mem [2**AW];
    logic                   r_credit, r_ovf, r_rd_valid;
    logic [FSAB_DID_W-1:0]  r_rd_did, r_rd_subdid;
    logic [FSAB_DATA_W-1:0] r_rd_data;

    logic                   w_empty, w_full, w_enq, w_deq, w_drop, w_hdr_slot;
    logic                   w_rd_issue, w_mem_we;
    logic [AW-1:0]          w_mem_waddr, w_head_addr;
    logic [CNT_W-1:0]       w_head_beats;
    logic                   w_unused_addr_bits;

    // Only the word-index bits of the byte address matter; the rest alias.
    assign w_unused_addr_bits = ^{fsabo_addr[FSAB_ADDR_W-1:AW+3], fsabo_addr[2:0]};

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == DEPTH);
    // A full FIFO still accepts a beat when an entry leaves in the same cycle.
    assign w_enq        = fsabo_valid && (!w_full || w_deq);
    assign w_drop       = fsabo_valid && w_full && !w_deq;
    assign w_head_addr  = r_q_addr[r_rd_ptr];
    assign w_head_beats = (r_q_len[r_rd_ptr] == '0) ? MAX_BEATS : {1'b0, r_q_len[r_rd_ptr]};
    // A new header may be taken in IDLE or alongside the last read issue.
    assign w_hdr_slot   = (r_state == S_IDLE) || ((r_state == S_RD) && (r_rem == CNT_W'(1)));

    // FIFO entry write on accepted beats
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_mode[r_wr_ptr]   <= fsabo_mode;
            r_q_did[r_wr_ptr]    <= fsabo_did;
            r_q_subdid[r_wr_ptr] <= fsabo_subdid;
            r_q_addr[r_wr_ptr]   <= fsabo_addr[AW+2:3];
            r_q_len[r_wr_ptr]    <= fsabo_len;
            r_q_data[r_wr_ptr]   <= fsabo_data;
            r_q_mask[r_wr_ptr]   <= fsabo_mask;
        end
    end

    // FIFO pointers, occupancy, credit return and sticky overflow flag
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_credit <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_enq) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_deq) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            if (w_enq && !w_deq)      r_count <= r_count + (PTR_W + 1)'(1);
            else if (!w_enq && w_deq) r_count <= r_count - (PTR_W + 1)'(1);
            r_credit <= w_deq;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // FSM state and burst context registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_rem    <= '0;
            r_did    <= '0;
            r_subdid <= '0;
        end else begin
            r_state  <= w_next_state;
            r_addr   <= w_next_addr;
            r_rem    <= w_next_rem;
            r_did    <= w_next_did;
            r_subdid <= w_next_subdid;
        end
    end

    // Next-state logic: burst progress first, then header decode if a slot is open
    always_comb begin
        w_next_state  = r_state;
        w_next_addr   = r_addr;
        w_next_rem    = r_rem;
        w_next_did    = r_did;
        w_next_subdid = r_subdid;
        w_deq         = 1'b0;
        w_rd_issue    = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_waddr   = r_addr;
        case (r_state)
            S_RD: begin
                w_rd_issue  = 1'b1;
                w_next_addr = r_addr + AW'(1);
                w_next_rem  = r_rem - CNT_W'(1);
                if (r_rem == CNT_W'(1)) w_next_state = S_IDLE;
            end
            S_WR: begin
                if (!w_empty) begin
                    w_deq       = 1'b1;
                    w_mem_we    = 1'b1;
                    w_next_addr = r_addr + AW'(1);
                    w_next_rem  = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) w_next_state = S_IDLE;
                end
            end
            S_IDLE:  ;
            default: w_next_state = S_IDLE;
        endcase
        if (w_hdr_slot && !w_empty) begin
            w_deq = 1'b1;
            if (!r_q_mode[r_rd_ptr]) begin
                w_next_state  = S_RD;
                w_next_addr   = w_head_addr;
                w_next_rem    = w_head_beats;
                w_next_did    = r_q_did[r_rd_ptr];
                w_next_subdid = r_q_subdid[r_rd_ptr];
            end else begin
                w_mem_we      = 1'b1;
                w_mem_waddr   = w_head_addr;
                w_next_addr   = w_head_addr + AW'(1);
                w_next_rem    = w_head_beats - CNT_W'(1);
                w_next_state  = (w_head_beats > CNT_W'(1)) ? S_WR : S_IDLE;
            end
        end
    end

    // RAM write port: byte-masked write of the dequeued beat
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < FSAB_MASK_W; i++) begin
                if (r_q_mask[r_rd_ptr][i]) r_mem[w_mem_waddr][8*i +: 8] <= r_q_data[r_rd_ptr][8*i +: 8];
            end
        end
    end

    // RAM read port with registered output; reset drops the stream at once
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_did    <= '0;
            r_rd_subdid <= '0;
        end else begin
            r_rd_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_data   <= r_mem[r_addr];
                r_rd_did    <= r_did;
                r_rd_subdid <= r_subdid;
            end
        end
    end

    assign fsabo_credit = r_credit;
    assign fsabi_valid  = r_rd_valid;
    assign fsabi_did    = r_rd_did;
    assign fsabi_subdid = r_rd_subdid;
    assign fsabi_data   = r_rd_data;
    assign ovf_err      = r_ovf;
    assign dbg_state    = r_state;
endmodule

// File: tb/tb_fsab_bram_responder.sv
// tb_fsab_bram_responder: directed bench for the FSAB BRAM responder.
// Drives beats at negedge under a credit budget; a monitor pops the expected
// queue on every fsabi_valid beat and counts credit pulses.
module tb_fsab_bram_responder;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        fsabo_valid = 1'b0;
  logic        fsabo_mode = 1'b0;
  logic [3:0]  fsabo_did = '0;
  logic [3:0]  fsabo_subdid = '0;
  logic [30:0] fsabo_addr = '0;
  logic [2:0]  fsabo_len = '0;
  logic [63:0] fsabo_data = '0;
  logic [7:0]  fsabo_mask = '0;
  logic        fsabo_credit, fsabi_valid, ovf_err;
  logic [3:0]  fsabi_did, fsabi_subdid;
  logic [63:0] fsabi_data;
  logic [1:0]  dbg_state;

  logic [71:0] exp_q[$];
  logic [63:0] mem_model [1024];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int credits_seen = 0;
  int beats_sent = 0;
  int rsp_count = 0;
  int last_rsp_cyc = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  fsab_bram_responder dut (
    .clk(clk), .rst_b(rst_b),
    .fsabo_valid(fsabo_valid), .fsabo_mode(fsabo_mode),
    .fsabo_did(fsabo_did), .fsabo_subdid(fsabo_subdid),
    .fsabo_addr(fsabo_addr), .fsabo_len(fsabo_len),
    .fsabo_data(fsabo_data), .fsabo_mask(fsabo_mask),
    .fsabo_credit(fsabo_credit),
    .fsabi_valid(fsabi_valid), .fsabi_did(fsabi_did),
    .fsabi_subdid(fsabi_subdid), .fsabi_data(fsabi_data),
    .ovf_err(ovf_err), .dbg_state(dbg_state)
  );

  // cycle counter and credit pulse counter
  always @(posedge clk) begin
    cyc++;
    if (fsabo_credit) credits_seen++;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [71:0] e;
    if (fsabi_valid) begin
      rsp_count++;
      last_rsp_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got did=%0d subdid=%0d data=%h, required no beat",
                 fsabi_did, fsabi_subdid, fsabi_data);
      end else begin
        e = exp_q.pop_front();
        if ({fsabi_did, fsabi_subdid, fsabi_data} !== e) begin
          n_bad++;
          $display("FAIL rsp_beat: got did=%0d subdid=%0d data=%h, required did=%0d subdid=%0d data=%h",
                   fsabi_did, fsabi_subdid, fsabi_data, e[71:68], e[67:64], e[63:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // driver: one beat per call, entered and left at a negedge
  task automatic send_beat(input logic mode, input logic [3:0] did, input logic [3:0] sub,
                           input logic [30:0] addr, input logic [2:0] len,
                           input logic [63:0] data, input logic [7:0] mask);
    int waited = 0;
    while ((8 - beats_sent + credits_seen) <= 0 && waited < 200) begin
      fsabo_valid = 1'b0;
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL credit_wait: no credit after %0d cycles, required a returned credit", waited);
    end
    fsabo_valid = 1'b1;
    fsabo_mode = mode;
    fsabo_did = did;
    fsabo_subdid = sub;
    fsabo_addr = addr;
    fsabo_len = len;
    fsabo_data = data;
    fsabo_mask = mask;
    beats_sent++;
    @(negedge clk);
  endtask

  // write burst: beat i carries d0 + i*step; data beats carry junk header fields
  task automatic wr_burst(input logic [30:0] addr, input logic [2:0] len, input logic [7:0] mask,
                          input logic [63:0] d0, input logic [63:0] step);
    int beats;
    logic [9:0] w;
    logic [63:0] d;
    beats = (len == 3'd0) ? 8 : int'(len);
    w = addr[12:3];
    for (int i = 0; i < beats; i++) begin
      d = d0 + step * 64'(i);
      for (int b = 0; b < 8; b++) if (mask[b]) mem_model[w][8*b +: 8] = d[8*b +: 8];
      if (i == 0) send_beat(1'b1, 4'hA, 4'hB, addr, len, d, mask);
      else        send_beat(1'b0, 4'(i), 4'(15 - i), 31'h7FFF_FFF8, len ^ 3'b101, d, mask);
      w = w + 10'd1;
    end
  endtask

  task automatic rd_hdr(input logic [30:0] addr, input logic [2:0] len, input logic [3:0] did,
                        input logic [3:0] sub);
    send_beat(1'b0, did, sub, addr, len, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
  endtask

  task automatic rd_burst(input logic [30:0] addr, input logic [2:0] len, input logic [3:0] did,
                          input logic [3:0] sub);
    int beats;
    logic [9:0] w;
    beats = (len == 3'd0) ? 8 : int'(len);
    w = addr[12:3];
    for (int i = 0; i < beats; i++) begin
      exp_q.push_back({did, sub, mem_model[w]});
      w = w + 10'd1;
    end
    rd_hdr(addr, len, did, sub);
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    fsabo_valid = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
    check({name, "_credits"}, 72'(credits_seen), 72'(beats_sent));
  endtask

  initial begin
    int s;
    int base;
    int n;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_fsabi_valid", 72'(fsabi_valid), 72'(0));
    check("rst_credit", 72'(fsabo_credit), 72'(0));
    check("rst_ovf", 72'(ovf_err), 72'(0));
    check("rst_fsabi_fields", {fsabi_did, fsabi_subdid, fsabi_data}, 72'(0));
    check("rst_state", 72'(dbg_state), 72'(0));
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // single write then read, latency from read header
    wr_burst(31'h10, 3'd1, 8'hFF, 64'h1122_3344_5566_7788, 64'd0);
    exp_q.push_back({4'd1, 4'd3, 64'h1122_3344_5566_7788});
    s = cyc;
    rd_hdr(31'h10, 3'd1, 4'd1, 4'd3);
    fsabo_valid = 1'b0;
    wait_quiet("t1");
    check("t1_latency", 72'(last_rsp_cyc - s), 72'(3));

    // len=4 write and read, back-to-back beats with fixed did/subdid
    wr_burst(31'h100, 3'd4, 8'hFF, 64'd0, 64'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back({4'd2, 4'd5, 64'(i)});
    s = cyc;
    base = rsp_count;
    rd_hdr(31'h100, 3'd4, 4'd2, 4'd5);
    fsabo_valid = 1'b0;
    wait_quiet("t2");
    check("t2_beats", 72'(rsp_count - base), 72'(4));
    check("t2_last_beat_cycle", 72'(last_rsp_cyc - s), 72'(6));

    // partial byte mask
    wr_burst(31'h40, 3'd1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    wr_burst(31'h40, 3'd1, 8'h0F, 64'd0, 64'd0);
    exp_q.push_back({4'd7, 4'd1, 64'hFFFF_FFFF_0000_0000});
    rd_hdr(31'h40, 3'd1, 4'd7, 4'd1);
    // mask 0 consumes a beat but writes nothing
    wr_burst(31'h40, 3'd1, 8'h00, 64'h1234_5678_9ABC_DEF0, 64'd0);
    exp_q.push_back({4'd7, 4'd2, 64'hFFFF_FFFF_0000_0000});
    rd_hdr(31'h40, 3'd1, 4'd7, 4'd2);
    wait_quiet("t3");

    // address wrap at word 1023 and upper-bit aliasing
    wr_burst(31'h1FF8, 3'd2, 8'hFF, 64'hAAAA_0000_0000_0001, 64'd1);
    exp_q.push_back({4'd6, 4'd0, 64'hAAAA_0000_0000_0001});
    rd_hdr(31'h1FF8, 3'd1, 4'd6, 4'd0);
    exp_q.push_back({4'd6, 4'd1, 64'hAAAA_0000_0000_0002});
    rd_hdr(31'h0, 3'd1, 4'd6, 4'd1);
    exp_q.push_back({4'd6, 4'd2, 64'hAAAA_0000_0000_0001});
    exp_q.push_back({4'd6, 4'd2, 64'hAAAA_0000_0000_0002});
    rd_hdr(31'h1FF8, 3'd2, 4'd6, 4'd2);
    exp_q.push_back({4'd6, 4'd3, 64'h1122_3344_5566_7788});
    rd_hdr(31'h4000_2010, 3'd1, 4'd6, 4'd3);
    wait_quiet("t4");

    // len=0 means 8 beats
    wr_burst(31'h200, 3'd0, 8'hFF, 64'h5000, 64'h11);
    for (int i = 0; i < 8; i++) exp_q.push_back({4'd3, 4'd3, 64'h5000 + 64'h11 * 64'(i)});
    base = rsp_count;
    rd_hdr(31'h200, 3'd0, 4'd3, 4'd3);
    fsabo_valid = 1'b0;
    wait_quiet("t4b");
    check("t4b_beats", 72'(rsp_count - base), 72'(8));

    // 8 read headers in 8 consecutive cycles
    base = credits_seen;
    for (int i = 0; i < 8; i++) rd_burst(31'h200 + 31'(8 * i), 3'd1, 4'(i), 4'(7 - i));
    wait_quiet("t5a");
    check("t5a_credits_returned", 72'(credits_seen - base), 72'(8));
    check("t5a_ovf", 72'(ovf_err), 72'(0));

    // fill the FIFO behind two long reads, then one beat with no credit
    rd_burst(31'h200, 3'd0, 4'd1, 4'd1);
    rd_burst(31'h200, 3'd0, 4'd2, 4'd2);
    for (int i = 0; i < 8; i++) rd_burst(31'h208 + 31'(8 * i) - 31'h8, 3'd1, 4'd8, 4'(i));
    fsabo_valid = 1'b1;
    fsabo_mode = 1'b0;
    fsabo_did = 4'hF;
    fsabo_subdid = 4'hF;
    fsabo_addr = 31'h10;
    fsabo_len = 3'd1;
    @(negedge clk);
    fsabo_valid = 1'b0;
    check("t5b_ovf_set", 72'(ovf_err), 72'(1));
    wait_quiet("t5b");
    check("t5b_ovf_sticky", 72'(ovf_err), 72'(1));

    // reset in the middle of a len=8 read after 3 beats
    base = rsp_count;
    rd_burst(31'h200, 3'd0, 4'd9, 4'd9);
    fsabo_valid = 1'b0;
    n = 0;
    while ((rsp_count - base) < 3 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("t6_beats_before_reset", 72'(rsp_count - base), 72'(3));
    rst_b = 1'b0;
    #1;
    exp_q.delete();
    check("t6_valid_drop", 72'(fsabi_valid), 72'(0));
    check("t6_credit", 72'(fsabo_credit), 72'(0));
    check("t6_state", 72'(dbg_state), 72'(0));
    check("t6_ovf_cleared", 72'(ovf_err), 72'(0));
    repeat (3) @(negedge clk);
    check("t6_valid_held", 72'(fsabi_valid), 72'(0));
    check("t6_beats_after_reset", 72'(rsp_count - base), 72'(3));
    beats_sent = credits_seen;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // normal service after reset; RAM keeps its contents
    exp_q.push_back({4'd4, 4'd4, 64'h1122_3344_5566_7788});
    rd_hdr(31'h10, 3'd1, 4'd4, 4'd4);
    wr_burst(31'h18, 3'd1, 8'hFF, 64'hCAFE_F00D_0000_0042, 64'd0);
    exp_q.push_back({4'd5, 4'd6, 64'hCAFE_F00D_0000_0042});
    rd_hdr(31'h18, 3'd1, 4'd5, 4'd6);
    wait_quiet("t7");
    check("t7_ovf", 72'(ovf_err), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
